// File: rtl/risc_pkg.sv
// Shared types for the RISC instruction sequencer: opcodes, phases and the
// registered control-strobe bundle.
package risc_pkg;

   localparam int OPCODE_W = 3;
   localparam int PHASE_W  = 3;

   typedef enum logic [OPCODE_W-1:0] {
      HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
      XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7
   } opcode_e;

   typedef enum logic [PHASE_W-1:0] {
      INST_ADDR = 3'd0, INST_FETCH = 3'd1, INST_LOAD = 3'd2, IDLE  = 3'd3,
      OP_ADDR   = 3'd4, OP_FETCH   = 3'd5, ALU_OP    = 3'd6, STORE = 3'd7
   } phase_e;

   typedef struct packed {
      logic sel;
      logic rd;
      logic wr;
      logic ld_ir;
      logic ld_ac;
      logic inc_pc;
      logic ld_pc;
      logic data_e;
      logic halt;
   } ctl_t;

   // Reset leaves the PC selected as the memory address, nothing else active.
   localparam ctl_t CTL_RESET = '{sel: 1'b1, default: 1'b0};

   function automatic logic is_aluop(input opcode_e op);
      return op inside {ADD, AND, XOR, LDA};
   endfunction

endpackage

// File: rtl/risc_sequencer_if.sv
// Sequencer control/status bundle. Optional instr_cnt is present only when
// RISC_SEQ_INSTR_CNT_EN is defined.
interface risc_sequencer_if;
   import risc_pkg::*;

   logic                enab;
   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic [PHASE_W-1:0]  phase;
   logic                sel;
   logic                rd;
   logic                wr;
   logic                ld_ir;
   logic                ld_ac;
   logic                inc_pc;
   logic                ld_pc;
   logic                data_e;
   logic                halt;
`ifdef RISC_SEQ_INSTR_CNT_EN
   logic [15:0]         instr_cnt;
`endif

   modport master (
      output enab, opcode, zero,
      input  phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
`ifdef RISC_SEQ_INSTR_CNT_EN
      , input instr_cnt
`endif
   );

   modport slave (
      input  enab, opcode, zero,
      output phase, sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
`ifdef RISC_SEQ_INSTR_CNT_EN
      , output instr_cnt
`endif
   );

endinterface

// File: rtl/risc_phase_ctr.sv
// Eight-phase counter: advances by one (wrapping STORE -> INST_ADDR) on every
// clock where advance is high, holds otherwise.
module risc_phase_ctr
   import risc_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   advance,
   output phase_e phase,
   output phase_e phase_nxt
);

   assign phase_nxt = phase_e'(phase + 3'd1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         phase <= INST_ADDR;
      else if (advance)
         phase <= phase_nxt;
   end

endmodule

// File: rtl/risc_sequencer.sv
// RISC instruction sequencer: one instruction per eight enabled clocks, all
// strobes registered from the upcoming phase. Optional RISC_SEQ_INSTR_CNT_EN
// adds a retired-instruction counter.
module risc_sequencer
   import risc_pkg::*;
(
   input logic              clk,
   input logic              rst,
   risc_sequencer_if.slave  bus
);

   phase_e  phase_q;
   phase_e  phase_nxt;
   opcode_e op;
   logic    advance;
   logic    aluop;
   ctl_t    ctl_q;
   ctl_t    ctl_d;

   assign op      = opcode_e'(bus.opcode);
   assign aluop   = is_aluop(op);
   // Once halted the whole sequencer freezes; only reset restarts it.
   assign advance = bus.enab & ~ctl_q.halt;

   risc_phase_ctr u_phase_ctr (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .phase     (phase_q),
      .phase_nxt (phase_nxt)
   );

   // Decode for the phase being entered so the registered strobes line up
   // with the phase value shown in the same cycle.
   always_comb begin
      // NOTE: default every field first so no path through the case infers a latch.
      ctl_d = '0;
      unique case (phase_nxt)
         INST_ADDR:  ctl_d.sel = 1'b1;
         INST_FETCH: begin
            ctl_d.sel = 1'b1;
            ctl_d.rd  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            ctl_d.sel   = 1'b1;
            ctl_d.rd    = 1'b1;
            ctl_d.ld_ir = 1'b1;
         end
         OP_ADDR: begin
            ctl_d.halt   = (op == HLT);
            ctl_d.inc_pc = (op != HLT);
         end
         OP_FETCH:   ctl_d.rd = aluop;
         ALU_OP: begin
            ctl_d.rd     = aluop;
            ctl_d.inc_pc = (op == SKZ) && bus.zero;
            ctl_d.ld_pc  = (op == JMP);
            ctl_d.data_e = (op == STO);
         end
         STORE: begin
            ctl_d.rd     = aluop;
            ctl_d.ld_ac  = aluop;
            ctl_d.ld_pc  = (op == JMP);
            ctl_d.wr     = (op == STO);
            ctl_d.data_e = (op == STO);
         end
         default: ctl_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ctl_q <= CTL_RESET;
      else if (advance)
         ctl_q <= ctl_d;
   end

`ifdef RISC_SEQ_INSTR_CNT_EN
   logic [15:0] instr_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         instr_cnt_q <= '0;
      else if (advance && phase_q == STORE)
         instr_cnt_q <= instr_cnt_q + 16'd1;
   end

   assign bus.instr_cnt = instr_cnt_q;
`endif

   assign bus.phase  = phase_q;
   assign bus.sel    = ctl_q.sel;
   assign bus.rd     = ctl_q.rd;
   assign bus.wr     = ctl_q.wr;
   assign bus.ld_ir  = ctl_q.ld_ir;
   assign bus.ld_ac  = ctl_q.ld_ac;
   assign bus.inc_pc = ctl_q.inc_pc;
   assign bus.ld_pc  = ctl_q.ld_pc;
   assign bus.data_e = ctl_q.data_e;
   assign bus.halt   = ctl_q.halt;

endmodule

// File: tb/tb_risc_sequencer.sv
// Directed bench for risc_sequencer: stimulus pushes hand-computed expected
// phase/strobe vectors, a negedge monitor pops and compares them.
module tb_risc_sequencer;
   import risc_pkg::*;

   // Strobe bit order: {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt}
   localparam logic [8:0] C_SEL = 9'h100;
   localparam logic [8:0] C_RD  = 9'h080;
   localparam logic [8:0] C_WR  = 9'h040;
   localparam logic [8:0] C_IR  = 9'h020;
   localparam logic [8:0] C_AC  = 9'h010;
   localparam logic [8:0] C_INC = 9'h008;
   localparam logic [8:0] C_LDP = 9'h004;
   localparam logic [8:0] C_DE  = 9'h002;
   localparam logic [8:0] C_HLT = 9'h001;
   localparam logic [8:0] C_NONE = 9'h000;

   typedef struct {
      logic [11:0] v;
      logic        cchk;
      logic [15:0] cnt;
      string       nm;
   } item_t;

   logic  clk = 1'b0;
   logic  rst;
   item_t exp_q[$];
   int    total = 0;
   int    bad = 0;

   always #5 clk = ~clk;

   risc_sequencer_if bus();

   risc_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Monitor: one expected entry per clock, compared half a cycle after the edge.
   item_t       mon_it;
   logic [11:0] mon_act;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_it  = exp_q.pop_front();
         mon_act = {bus.phase, bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
                    bus.inc_pc, bus.ld_pc, bus.data_e, bus.halt};
         total++;
         if (mon_act !== mon_it.v) begin
            bad++;
            $display("FAIL %s: got phase=%0d ctl=%09b, want phase=%0d ctl=%09b",
                     mon_it.nm, mon_act[11:9], mon_act[8:0], mon_it.v[11:9], mon_it.v[8:0]);
         end
`ifdef RISC_SEQ_INSTR_CNT_EN
         if (mon_it.cchk) begin
            total++;
            if (bus.instr_cnt !== mon_it.cnt) begin
               bad++;
               $display("FAIL %s_cnt: got instr_cnt=%0d, want %0d",
                        mon_it.nm, bus.instr_cnt, mon_it.cnt);
            end
         end
`endif
      end
   end

   function automatic logic [8:0] fetch_ctl(input int p);
      case (p)
         0:       return C_SEL;
         1:       return C_SEL | C_RD;
         default: return C_SEL | C_RD | C_IR;
      endcase
   endfunction

   // Drive one clock's inputs just after the monitor's sample point and queue
   // what the following edge must produce.
   task automatic cyc(input logic r, input logic e, input opcode_e op, input logic z,
                      input int ph, input logic [8:0] c, input string nm,
                      input logic cchk = 1'b0, input logic [15:0] cnt = 16'd0);
      item_t it;
      @(negedge clk);
      #1;
      rst        = r;
      bus.enab   = e;
      bus.opcode = op;
      bus.zero   = z;
      it.v    = {ph[2:0], c};
      it.cchk = cchk;
      it.cnt  = cnt;
      it.nm   = nm;
      exp_q.push_back(it);
   endtask

   // One full instruction from phase 0 back to phase 0.
   task automatic instr(input opcode_e op, input logic z,
                        input logic [8:0] t4, input logic [8:0] t5,
                        input logic [8:0] t6, input logic [8:0] t7,
                        input string nm, input logic cchk, input logic [15:0] cnt);
      for (int k = 1; k <= 8; k++) begin
         int         ph;
         logic [8:0] c;
         ph = k % 8;
         case (ph)
            4:       c = t4;
            5:       c = t5;
            6:       c = t6;
            7:       c = t7;
            default: c = fetch_ctl(ph);
         endcase
         cyc(1'b1, 1'b1, op, z, ph, c, $sformatf("%s_p%0d", nm, ph), cchk && (k == 8), cnt);
      end
   endtask

   initial begin
      rst        = 1'b0;
      bus.enab   = 1'b0;
      bus.opcode = HLT;
      bus.zero   = 1'b0;
      repeat (2) @(negedge clk);

      cyc(1'b0, 1'b0, ADD, 1'b0, 0, C_SEL, "reset_state");
      cyc(1'b1, 1'b0, ADD, 1'b0, 0, C_SEL, "enab_low_idle");

      // ADD up to phase 5, then reset mid-instruction.
      for (int k = 1; k <= 5; k++)
         cyc(1'b1, 1'b1, ADD, 1'b0, k, (k < 4) ? fetch_ctl(k) : ((k == 4) ? C_INC : C_RD),
             $sformatf("add_p%0d", k));
      cyc(1'b0, 1'b1, ADD, 1'b0, 0, C_SEL, "async_rst_p5");

      instr(LDA, 1'b0, C_INC, C_RD, C_RD, C_RD | C_AC, "lda", 1'b0, 16'd0);
      instr(STO, 1'b0, C_INC, C_NONE, C_DE, C_WR | C_DE, "sto", 1'b1, 16'd2);
      instr(SKZ, 1'b1, C_INC, C_NONE, C_INC, C_NONE, "skz_z1", 1'b0, 16'd0);
      instr(SKZ, 1'b0, C_INC, C_NONE, C_NONE, C_NONE, "skz_z0", 1'b0, 16'd0);

      // ADD with a three-cycle stall in phase 2.
      for (int k = 1; k <= 2; k++)
         cyc(1'b1, 1'b1, ADD, 1'b0, k, fetch_ctl(k), $sformatf("stall_add_p%0d", k));
      repeat (3) cyc(1'b1, 1'b0, ADD, 1'b0, 2, C_SEL | C_RD | C_IR, "stall_hold_p2");
      for (int k = 3; k <= 8; k++)
         cyc(1'b1, 1'b1, ADD, 1'b0, k % 8,
             (k < 4) ? fetch_ctl(k) : ((k == 4) ? C_INC : ((k == 8) ? C_SEL :
             ((k == 7) ? (C_RD | C_AC) : ((k == 5 || k == 6) ? C_RD : C_NONE)))),
             $sformatf("stall_add_p%0d", k % 8), k == 8, 16'd5);

      instr(JMP, 1'b0, C_INC, C_NONE, C_LDP, C_LDP, "jmp", 1'b1, 16'd6);

      // HLT: freeze at phase 4 with only halt set, regardless of enab.
      for (int k = 1; k <= 3; k++)
         cyc(1'b1, 1'b1, HLT, 1'b0, k, fetch_ctl(k), $sformatf("hlt_p%0d", k));
      cyc(1'b1, 1'b1, HLT, 1'b0, 4, C_HLT, "hlt_enter");
      for (int k = 0; k < 20; k++)
         cyc(1'b1, (k % 5) != 3, HLT, 1'b1, 4, C_HLT, "halted_frozen", k == 19, 16'd6);

      cyc(1'b0, 1'b1, LDA, 1'b0, 0, C_SEL, "rst_clears_halt", 1'b1, 16'd0);
      cyc(1'b1, 1'b1, LDA, 1'b0, 1, C_SEL | C_RD, "restart_p1");

      // Let the monitor drain, bounded.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/risc_sequencer.md
Name: risc_sequencer

Overview:
- 8-phase instruction sequencer for the RISC core; one instruction executes every 8 enabled clocks.
- Drives the program-counter strobes (`inc_pc`, `ld_pc`), the memory strobes (`rd`, `wr`), the address mux select (`sel`), the IR/accumulator loads and the data-bus enable.
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag.
- Outputs are registered and glitch-free.

Parameters:
- `OPCODE_W`, 3, opcode field width; fixed ISA, any other value is illegal.
- `PHASE_W`, 3, phase counter width; must satisfy 2**`PHASE_W` = 8.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous active-low reset; asserted when 0.
- `enab`  in  1  run enable; 0 freezes the phase and all outputs.
- `opcode`  in  `OPCODE_W`  IR opcode field; stable from IDLE through STORE.
- `zero`  in  1  accumulator == 0 flag.
- `phase`  out  `PHASE_W`  current phase.
- `sel`  out  1  1 selects PC as memory address, 0 selects the IR operand address.
- `rd`  out  1  memory read strobe.
- `wr`  out  1  memory write strobe.
- `ld_ir`  out  1  instruction register load.
- `ld_ac`  out  1  accumulator load.
- `inc_pc`  out  1  PC increment (PC counter `enab`).
- `ld_pc`  out  1  PC load (PC counter `load`).
- `data_e`  out  1  accumulator drives the data bus.
- `halt`  out  1  sticky halted indication.

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD|AND|XOR|LDA.
- Phases: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Phase counter: +1 mod 8 on each clk with `enab`=1 and halted=0; STORE wraps to INST_ADDR.
- Outputs are registered from the next phase plus current `opcode`/`zero`, so each output is valid in the same cycle `phase` shows its value. Zero combinational paths from inputs to outputs.
- Per-phase asserts (all unlisted outputs are 0):
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc` if opcode != HLT; `halt` if opcode == HLT.
  - OP_FETCH: `rd` if ALUOP.
  - ALU_OP: `rd` if ALUOP; `inc_pc` if SKZ & `zero`; `ld_pc` if JMP; `data_e` if STO.
  - STORE: `rd` and `ld_ac` if ALUOP; `ld_pc` if JMP; `wr` and `data_e` if STO.
- Halt: entering OP_ADDR with HLT sets internal halted=1 and `halt`=1, and the phase freezes at 4. While halted, every strobe is 0 regardless of `enab`. Only reset clears halt.
- `enab`=0: phase and all output registers hold their values; a strobe high before the stall stays high. The PC/memory consumers gate with `enab` themselves.
- SKZ with `zero`=0: no strobe in ALU_OP/STORE; the instruction acts as a NOP.
- `zero` is sampled only on the edge entering ALU_OP.
- Reset (async, any phase including mid-instruction): `phase`=0, halted=0, `sel`=1, all other outputs 0. First enabled edge after deassertion moves to phase 1.

Optional Feature:
- Macro: `RISC_SEQ_INSTR_CNT_EN`.
- When defined: adds output `instr_cnt` [15:0], reset to 0. It increments on each enabled STORE→INST_ADDR wrap and wraps 0xFFFF→0. It never counts while halted.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `risc_pkg`: opcode enum (HLT..JMP), phase enum (INST_ADDR..STORE), `OPCODE_W`, `PHASE_W`, and an `is_aluop()` function.
- One natural sub-module: `risc_phase_ctr`, the 3-bit enabled, freezable phase counter with async active-low reset.
- Output decode stays in the top level.

Test Plan:
- Reset at phase 5 with opcode=ADD → `phase`=0, `sel`=1, all other outputs 0 immediately, before any clock edge.
- opcode=LDA, `enab`=1, 8 clocks → `rd` high in phases 1,2,3,5,6,7; `ld_ac` only in phase 7; `inc_pc` only in phase 4; `phase` returns to 0.
- opcode=STO → `data_e` high in phases 6–7, `wr` only in phase 7, `rd` low in phases 5–7.
- Back-to-back: opcode=SKZ with `zero`=1 gives `inc_pc` in phases 4 and 6. Next instruction with `zero`=0 gives `inc_pc` in phase 4 only.
- opcode=JMP gives `ld_pc` in phases 6–7, `inc_pc` in phase 4. Then opcode=HLT: at phase 4 `halt`=1, `inc_pc`=0; after 20 more clocks `phase` is still 4 and all strobes are 0.
- `enab` low for 3 cycles in phase 2 → `phase`=2 and `ld_ir`=1 held. With `RISC_SEQ_INSTR_CNT_EN` defined, `instr_cnt` reads 2 after two complete instructions.
